// File: rtl/stream_demux_1ton_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
// The FSM state enum and the destination range check live here so the top and bench agree.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } demux_state_e;

    // A destination index is usable only when it names an existing channel.
    function automatic logic sel_valid(input int sel, input int n);
        return (sel >= 0) && (sel < n);
    endfunction

endpackage

// File: rtl/stream_demux_1ton_if.sv
// Bundle of the input stream, the N output streams and the drop flag of the demultiplexer.
// The master modport is the side that sources beats and sinks channels; slave is the demux itself.
interface stream_demux_1ton_if #(
    parameter int WIDTH = 32,
    parameter int N     = 8
);
    localparam int SW = $clog2(N);

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic [SW-1:0]    s_sel;
    logic             s_last;

    logic [N-1:0]     m_valid;
    logic [N-1:0]     m_ready;
    logic [WIDTH-1:0] m_data [0:N-1];
    logic [N-1:0]     m_last;

    logic             err_drop;

    modport master (
        output s_valid, s_data, s_sel, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, err_drop
    );

    modport slave (
        input  s_valid, s_data, s_sel, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, err_drop
    );

endinterface

// File: rtl/stream_demux_1ton_slot.sv
// One-entry registered output slot; it can take a new beat when empty or being drained,
// so a channel whose consumer keeps m_ready high sustains one beat per cycle.
module demux_out_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             can_accept
);

    assign can_accept = !m_valid || m_ready;

    // A write wins over a drain, so a slot refilled while draining stays valid with the new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (wr_en) begin
            m_valid <= 1'b1;
            m_data  <= wr_data;
            m_last  <= wr_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1ton.sv
// Routes a valid/ready packet stream to one of N registered output channels, with the
// destination locked on the first beat and out-of-range destinations discarded.
module stream_demux_1ton
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 8
) (
    input logic                clk,
    input logic                rst_n,
    stream_demux_1ton_if.slave bus
);

    localparam int SW = $clog2(N);

    demux_state_e     state_q;
    demux_state_e     state_d;
    logic [SW-1:0]    dst_q;
    logic [SW-1:0]    cur_dst;
    logic             cur_ok;
    logic             accept;
    logic             drop_start;
    logic             err_q;

    logic [N-1:0]     slot_can;
    logic [N-1:0]     wr_en;
    logic [N-1:0]     slot_valid;
    logic [N-1:0]     slot_last;
    logic [WIDTH-1:0] slot_data [0:N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && !bus.s_last) state_d = cur_ok ? FWD : DROP;
            FWD:  if (accept && bus.s_last)  state_d = IDLE;
            DROP: if (accept && bus.s_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In IDLE the live s_sel steers the beat; afterwards the locked dst_q does.
    // DROP leaves cur_ok low so the source is always ready and nothing is written.
    always_comb begin
        cur_dst     = (state_q == IDLE) ? bus.s_sel : dst_q;
        cur_ok      = (state_q == FWD) ||
                      ((state_q == IDLE) && sel_valid(int'(bus.s_sel), N));
        bus.s_ready = 1'b0;
        if (rst_n) begin
            bus.s_ready = cur_ok ? slot_can[cur_dst] : 1'b1;
        end
        accept      = bus.s_valid && bus.s_ready;
        drop_start  = accept && (state_q == IDLE) && !cur_ok;
        wr_en       = '0;
        for (int i = 0; i < N; i++) begin
            wr_en[i] = accept && cur_ok && (cur_dst == SW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= drop_start;
            if ((state_q == IDLE) && accept && !bus.s_last && cur_ok) begin
                dst_q <= bus.s_sel;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_out_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (wr_en[g]),
            .wr_data    (bus.s_data),
            .wr_last    (bus.s_last),
            .m_valid    (slot_valid[g]),
            .m_ready    (bus.m_ready[g]),
            .m_data     (slot_data[g]),
            .m_last     (slot_last[g]),
            .can_accept (slot_can[g])
        );
    end

    assign bus.m_valid  = slot_valid;
    assign bus.m_last   = slot_last;
    assign bus.m_data   = slot_data;
    assign bus.err_drop = err_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: an N=8 and an N=5 instance share one driver; a per-channel
// expected-beat queue model plus protocol checks scores directed and random traffic.
module tb_stream_demux_1ton;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_demux_1ton_if #(.WIDTH(32), .N(8)) if8 ();
    stream_demux_1ton_if #(.WIDTH(32), .N(5)) if5 ();

    stream_demux_1ton #(.WIDTH(32), .N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    stream_demux_1ton #(.WIDTH(32), .N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

    logic        sv;
    logic        slast;
    logic [31:0] sd;
    logic [2:0]  ssel;
    logic [7:0]  mr;
    bit          tgt;
    bit          rand_ready;

    assign if8.s_valid = sv & ~tgt;
    assign if8.s_data  = sd;
    assign if8.s_sel   = ssel;
    assign if8.s_last  = slast;
    assign if8.m_ready = mr;
    assign if5.s_valid = sv & tgt;
    assign if5.s_data  = sd;
    assign if5.s_sel   = ssel;
    assign if5.s_last  = slast;
    assign if5.m_ready = mr[4:0];

    wire cur_ready = tgt ? if5.s_ready : if8.s_ready;

    logic [7:0]  mv [2];
    logic [7:0]  ml [2];
    logic [31:0] md [2][8];
    logic        er [2];

    always_comb begin
        mv[0] = if8.m_valid;
        ml[0] = if8.m_last;
        mv[1] = {3'b000, if5.m_valid};
        ml[1] = {3'b000, if5.m_last};
        er[0] = if8.err_drop;
        er[1] = if5.err_drop;
        for (int c = 0; c < 8; c++) md[0][c] = if8.m_data[c];
        for (int c = 0; c < 5; c++) md[1][c] = if5.m_data[c];
        for (int c = 5; c < 8; c++) md[1][c] = '0;
    end

    int          total = 0;
    int          bad   = 0;
    logic [32:0] expq [2][8][$];
    int          got_err [2];
    int          exp_err [2];
    int          seen [2][8];
    bit          in_pkt [2];
    bit          pkt_drop [2];
    int          pkt_dst [2];

    logic [7:0]  pv [2];
    logic [7:0]  pr [2];
    logic [7:0]  pl [2];
    logic [31:0] pd [2][8];

    function automatic int nch(input int t);
        return (t == 1) ? 5 : 8;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet-level model: destination chosen on the first beat, whole packet dropped if out of range.
    task automatic modelAccept(input int t, input logic [2:0] sel, input logic [31:0] data, input logic last);
        if (!in_pkt[t]) begin
            pkt_dst[t]  = int'(sel);
            pkt_drop[t] = (int'(sel) >= nch(t));
            if (pkt_drop[t]) exp_err[t]++;
        end
        if (!pkt_drop[t]) expq[t][pkt_dst[t]].push_back({last, data});
        in_pkt[t] = !last;
    endtask

    task automatic resetModel();
        for (int t = 0; t < 2; t++) begin
            in_pkt[t] = 1'b0;
            for (int c = 0; c < 8; c++) expq[t][c].delete();
        end
    endtask

    task automatic applyStimulus(input int t, input logic [2:0] sel, input logic [31:0] data,
                                 input logic last, output int waited);
        bit done;
        done    = 1'b0;
        waited  = 0;
        tgt     = (t == 1);
        ssel    = sel;
        sd      = data;
        slast   = last;
        sv      = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (cur_ready === 1'b1) begin
                modelAccept(t, sel, data, last);
                done = 1'b1;
            end else if (waited >= 200) begin
                checkOutput("accept_timeout", 64'(waited), 64'(0));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (rand_ready) mr = 8'($urandom);
            end
        end
        sv = 1'b0;
    endtask

    task automatic drainAll();
        int left;
        mr = 8'hff;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        left = 0;
        for (int t = 0; t < 2; t++)
            for (int c = 0; c < 8; c++) left += expq[t][c].size();
        checkOutput("drain_left", 64'(left), 64'(0));
    endtask

    // Scoreboard and protocol watcher, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        for (int t = 0; t < 2; t++) begin
            if (!rst_n) begin
                pv[t] = '0;
            end else begin
                if (er[t]) got_err[t]++;
                for (int c = 0; c < nch(t); c++) begin
                    if (pv[t][c] && !pr[t][c]) begin
                        checkOutput("hold_valid", 64'(mv[t][c]), 64'(1));
                        checkOutput("hold_data", 64'({ml[t][c], md[t][c]}), 64'({pl[t][c], pd[t][c]}));
                    end
                    if (mv[t][c] && mr[c]) begin
                        checkOutput("beat_expected", 64'(expq[t][c].size() > 0), 64'(1));
                        if (expq[t][c].size() > 0) begin
                            checkOutput("out_beat", 64'({ml[t][c], md[t][c]}), 64'(expq[t][c][0]));
                            void'(expq[t][c].pop_front());
                            seen[t][c]++;
                        end
                    end
                end
                pv[t] = mv[t];
                pr[t] = mr;
                pl[t] = ml[t];
                for (int c = 0; c < 8; c++) pd[t][c] = md[t][c];
            end
        end
    end

    initial begin
        int w;
        int s0;
        int s6;
        int e0;
        int len;
        logic [2:0] psel;

        for (int t = 0; t < 2; t++) begin
            got_err[t] = 0;
            exp_err[t] = 0;
            in_pkt[t]  = 1'b0;
            pkt_drop[t] = 1'b0;
            pkt_dst[t] = 0;
            pv[t] = '0;
            pr[t] = '0;
            pl[t] = '0;
            for (int c = 0; c < 8; c++) begin
                seen[t][c] = 0;
                pd[t][c]   = '0;
            end
        end
        sv = 1'b1; sd = '0; ssel = '0; slast = 1'b0; mr = '0; tgt = 1'b0; rand_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        checkOutput("rst_s_ready8", 64'(if8.s_ready), 64'(0));
        checkOutput("rst_s_ready5", 64'(if5.s_ready), 64'(0));
        checkOutput("rst_m_valid8", 64'(if8.m_valid), 64'(0));
        checkOutput("rst_m_valid5", 64'(if5.m_valid), 64'(0));
        checkOutput("rst_m_data", 64'(if8.m_data[3]), 64'(0));
        checkOutput("rst_m_last", 64'(if8.m_last), 64'(0));
        checkOutput("rst_err", 64'({if8.err_drop, if5.err_drop}), 64'(0));
        sv = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mr = 8'hff;

        $display("[TB] single beat");
        applyStimulus(0, 3'd5, 32'hDEADBEEF, 1'b1, w);
        checkOutput("single_wait", 64'(w), 64'(0));
        checkOutput("single_valid", 64'(if8.m_valid), 64'(8'h20));
        checkOutput("single_data", 64'(if8.m_data[5]), 64'(32'hDEADBEEF));
        checkOutput("single_last", 64'(if8.m_last[5]), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("single_one_cycle", 64'(if8.m_valid), 64'(0));

        $display("[TB] packet lock");
        s0 = seen[0][2];
        s6 = seen[0][6];
        for (int i = 0; i < 4; i++)
            applyStimulus(0, (i == 0) ? 3'd2 : 3'd6, 32'hA000_0000 + 32'(i), (i == 3), w);
        checkOutput("lock_valid", 64'(if8.m_valid), 64'(8'h04));
        checkOutput("lock_last", 64'(if8.m_last[2]), 64'(1));
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("lock_count2", 64'(seen[0][2] - s0), 64'(4));
        checkOutput("lock_count6", 64'(seen[0][6] - s6), 64'(0));

        $display("[TB] backpressure");
        s0 = seen[0][3];
        mr = 8'hf7;
        applyStimulus(0, 3'd3, 32'hB000_0000, 1'b0, w);
        tgt = 1'b0; ssel = 3'd3; sd = 32'hB000_0001; slast = 1'b0; sv = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checkOutput("bp_s_ready", 64'(if8.s_ready), 64'(0));
        checkOutput("bp_valid", 64'(if8.m_valid[3]), 64'(1));
        checkOutput("bp_data", 64'(if8.m_data[3]), 64'(32'hB000_0000));
        @(posedge clk);
        #1 mr = 8'hff;
        applyStimulus(0, 3'd3, 32'hB000_0001, 1'b0, w);
        checkOutput("bp_resume", 64'(w), 64'(0));
        applyStimulus(0, 3'd3, 32'hB000_0002, 1'b1, w);
        checkOutput("bp_throughput", 64'(w), 64'(0));
        drainAll();
        checkOutput("bp_count", 64'(seen[0][3] - s0), 64'(3));

        $display("[TB] channel independence");
        mr = 8'hfd;
        applyStimulus(0, 3'd1, 32'hC000_0001, 1'b1, w);
        applyStimulus(0, 3'd4, 32'hC000_0004, 1'b1, w);
        checkOutput("indep_wait", 64'(w), 64'(0));
        checkOutput("indep_valid", 64'(if8.m_valid & 8'h12), 64'(8'h12));
        checkOutput("indep_data", 64'(if8.m_data[4]), 64'(32'hC000_0004));
        drainAll();

        $display("[TB] invalid destination");
        e0 = got_err[1];
        applyStimulus(1, 3'd6, 32'hD000_0000, 1'b0, w);
        checkOutput("drop_wait", 64'(w), 64'(0));
        checkOutput("drop_pulse", 64'(if5.err_drop), 64'(1));
        applyStimulus(1, 3'd6, 32'hD000_0001, 1'b0, w);
        checkOutput("drop_no_repulse", 64'(if5.err_drop), 64'(0));
        checkOutput("drop_valid_b1", 64'(if5.m_valid), 64'(0));
        applyStimulus(1, 3'd6, 32'hD000_0002, 1'b1, w);
        checkOutput("drop_valid_b2", 64'(if5.m_valid), 64'(0));
        drainAll();
        checkOutput("drop_pulse_count", 64'(got_err[1] - e0), 64'(1));
        applyStimulus(1, 3'd0, 32'hD000_0003, 1'b1, w);
        checkOutput("after_drop_valid", 64'(if5.m_valid), 64'(5'b00001));
        checkOutput("after_drop_data", 64'(if5.m_data[0]), 64'(32'hD000_0003));
        drainAll();

        $display("[TB] reset mid-packet");
        applyStimulus(0, 3'd2, 32'hE000_0000, 1'b0, w);
        applyStimulus(0, 3'd2, 32'hE000_0001, 1'b0, w);
        tgt = 1'b0; ssel = 3'd2; sd = 32'hE000_0002; slast = 1'b0; sv = 1'b1;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midrst_valid", 64'(if8.m_valid), 64'(0));
        checkOutput("midrst_s_ready", 64'(if8.s_ready), 64'(0));
        sv = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("midrst_idle", 64'(dut8.state_q), 64'(IDLE));
        applyStimulus(0, 3'd7, 32'hF000_0007, 1'b1, w);
        checkOutput("midrst_route", 64'(if8.m_valid), 64'(8'h80));
        checkOutput("midrst_data", 64'(if8.m_data[7]), 64'(32'hF000_0007));
        drainAll();

        $display("[TB] random traffic");
        rand_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            for (int p = 0; p < 30; p++) begin
                len  = int'($urandom_range(1, 4));
                psel = 3'($urandom_range(0, 7));
                for (int b = 0; b < len; b++) begin
                    mr = 8'($urandom);
                    applyStimulus(t, (b == 0) ? psel : 3'($urandom), $urandom, (b == len - 1), w);
                end
            end
        end
        rand_ready = 1'b0;
        drainAll();
        checkOutput("err_count8", 64'(got_err[0]), 64'(exp_err[0]));
        checkOutput("err_count5", 64'(got_err[1]), 64'(exp_err[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_1ton.md
# stream_demux_1ton

- Routes one valid/ready input stream to one of N output streams, selected per packet by a destination index.
- A packet is one or more beats ending on `s_last`. The destination is sampled on the first beat and held until the last beat is accepted.
- Each output has a one-entry registered slot, so outputs are registered and independent.
- Sits at the distribution end of the datapath, where one source feeds N parallel consumers.

## Interface
- `WIDTH`, 32: bit-width of each data beat.
- `N`, 8: number of output channels; N ≥ 2.
- `SW`, $clog2(N): destination index width (derived; do not override).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_data`  in  WIDTH  input beat payload.
- `s_sel`  in  SW  destination index; sampled on a packet's first beat only.
- `s_last`  in  1  final beat of the packet.
- `m_valid`  out  [N]  per-channel output valid.
- `m_ready`  in  [N]  per-channel output ready.
- `m_data`  out  [WIDTH] x N  per-channel payload (unpacked array [0:N-1]).
- `m_last`  out  [N]  per-channel last flag.
- `err_drop`  out  1  one-cycle pulse when a packet is discarded for an invalid destination.

## Operation
- **States:**
  - IDLE: no packet in flight.
  - FWD: packet in flight, locked destination `dst_q`.
  - DROP: packet in flight, being discarded.
- **IDLE:** destination is `s_sel`.
  - If `s_sel` < N: `s_ready` = slot[`s_sel`] empty, or slot[`s_sel`] being drained this cycle (`m_valid && m_ready`).
  - On an accepted beat with `s_last`=0: latch `dst_q` = `s_sel` and go to FWD.
  - With `s_last`=1 the packet is single-beat; stay in IDLE.
- **Invalid destination in IDLE:** `s_sel` ≥ N (possible only when N is not a power of two).
  - `s_ready`=1 and the beat is discarded.
  - `err_drop` pulses the next cycle.
  - Go to DROP if `s_last`=0, otherwise stay in IDLE.
- **FWD:**
  - `s_sel` is ignored.
  - `s_ready` follows the slot[`dst_q`] rule above.
  - An accepted beat with `s_last`=1 returns the FSM to IDLE.
- **DROP:**
  - `s_ready`=1 and all beats are discarded.
  - An accepted `s_last` returns the FSM to IDLE.
  - `err_drop` pulses once per dropped packet, not per beat.
- **Slot write:** an accepted beat loads `data`/`last` into the destination slot and sets its valid. A slot that is drained and written in the same cycle stays valid with the new beat.
- **Slot drain:** `m_valid[i] && m_ready[i]` clears slot i, unless slot i is refilled in the same cycle.
- **Channel independence:** non-destination channels drain independently. A stalled channel never blocks a packet routed to another channel once the FSM is in IDLE.
- **Protocol rules (outputs):**
  - `m_valid[i]` never deasserts without a handshake.
  - `m_data`/`m_last` stay stable while `m_valid[i]` && !`m_ready[i]`.
- **Protocol rules (inputs):** the source must hold `s_data`/`s_sel`/`s_last` stable while `s_valid` && !`s_ready`. The design does not check this.

## Timing
- **Latency:** an input beat accepted at edge k gives `m_valid[dst]`=1 after edge k, i.e. a 1-cycle latency.
- **Throughput:** one beat per cycle to a channel whose `m_ready` stays high.
- **Combinational paths:**
  - `s_ready` depends combinationally on `m_ready[dst]`, `s_sel` (in IDLE) and the FSM state.
  - No combinational path from `s_*` to `m_*`.
- **Reset (asynchronous assert, synchronous deassert handled upstream):**
  - FSM = IDLE.
  - All `m_valid` = 0, all `m_data` = 0, all `m_last` = 0.
  - `err_drop` = 0.
  - `s_ready` = 0 while `rst_n` = 0.
- **Reset mid-packet:** in-flight slot contents and the lock are discarded. After release, the next beat is treated as a first beat.

## Structure
- **Package `demux_pkg`:**
  - `demux_state_e` enum (IDLE, FWD, DROP).
  - Helper function `sel_valid(sel, n)`.
- **Sub-module `demux_out_slot`:** one-entry register slice, parameter `WIDTH`.
  - Ports: `clk`, `rst_n`, `wr_en`, `wr_data`, `wr_last`, `m_valid`, `m_ready`, `m_data`, `m_last`, and `can_accept` (empty or draining).
  - Instantiated N times in a generate loop.
- **Top level:** contains the FSM, the `dst_q` register, the `s_ready` mux, and the write-enable decode.

## Test plan
- **Single beat:** N=8, all `m_ready`=1; send one beat `s_sel`=5, `s_data`=0xDEADBEEF, `s_last`=1.
  - Required: `m_valid[5]` high for exactly 1 cycle, with `m_data[5]`=0xDEADBEEF and `m_last[5]`=1.
  - Required: all other channels stay idle.
- **Packet lock:** send 4-beat packet with `s_sel`=2 on beat 0, and `s_sel` changed to 6 on beats 1–3.
  - Required: all 4 beats appear on channel 2, in order, with `m_last` set on beat 3 only.
- **Backpressure:** `m_ready[3]`=0; stream 3 beats to channel 3.
  - Required: first beat held in slot 3 and `s_ready`=0 with data stable.
  - Then raise `m_ready[3]`: the remaining beats drain at 1 per cycle with no loss or duplication.
- **Channel independence:** `m_ready[1]`=0 with slot 1 full; send a single-beat packet to channel 4.
  - Required: accepted immediately, and `m_valid[4]` high the next cycle.
- **Invalid destination:** N=5; send 3-beat packet with `s_sel`=6.
  - Required: all 3 beats accepted and no `m_valid` asserted.
  - Required: `err_drop` pulses exactly once.
  - Required: the next packet, `s_sel`=0, is delivered normally.
- **Reset mid-packet:** assert `rst_n`=0 during beat 2 of a 4-beat FWD packet.
  - Required: all `m_valid`=0 immediately, and FSM in IDLE after release.
  - Required: a new packet to channel 7 is routed correctly.
